traffic_sink_checker: RTL and testbench

Receive-side endpoint for the `massive_traffic_injector` AXI-Stream packet output. It accepts packets under a programmable pseudo-random backpressure pattern and parses each packet's queue ID and per-beat word counter. It checks framing (beat count, `tlast`, `tkeep`) and, optionally, strict round-robin queue order, and exposes packet/beat counters plus sticky error flags. It sits on the far end of the injector stream, in simulation benches and in on-chip loopback self-test.

---
 rtl/traffic_sink_pkg.sv | 21 ++
 rtl/lfsr_backpressure_gen.sv | 35 +++
 rtl/traffic_sink_checker.sv | 157 +++++++++++++++
 tb/tb_traffic_sink_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_sink_pkg.sv
// Shared constants, types and helpers for the traffic sink checker.
package traffic_sink_pkg;

    // Field positions inside each beat's data word.
    localparam int WORD_CNT_LSB   = 0;
    localparam int WORD_CNT_WIDTH = 16;
    localparam int QUEUE_ID_LSB   = 16;

    // Receive parser position within a packet.
    typedef enum logic [1:0] {
        HEAD,
        BODY,
        DROP
    } sink_state_t;

    // Number of stream beats in one fixed-length packet.
    function automatic int beats(input int pkt_len_bytes, input int data_width);
        return pkt_len_bytes / (data_width / 8);
    endfunction

endpackage

// File: rtl/lfsr_backpressure_gen.sv
// Pseudo-random backpressure source: a 32-bit Galois LFSR whose low byte
// is compared against a throttle level to produce a registered ready.
module lfsr_backpressure_gen #(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] ready_throttle,
    output logic       tready
);

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic [31:0] lfsr;
    logic [31:0] lfsr_next;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    // Advance the LFSR while enabled and register the next ready decision.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= LFSR_SEED;
            tready <= 1'b0;
        end else if (enable) begin
            lfsr   <= lfsr_next;
            tready <= (ready_throttle == 8'd0) || (lfsr[7:0] >= ready_throttle);
        end else begin
            tready <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_sink_checker.sv
// Receive endpoint for the injector packet stream: applies backpressure,
// checks framing and optional round-robin queue order, and counts traffic.
module traffic_sink_checker
    import traffic_sink_pkg::*;
#(
    parameter int          QUEUE_INDEX_WIDTH = 16,
    parameter int          DATA_WIDTH        = 512,
    parameter int          PKT_LEN_BYTES     = 1536,
    parameter int          CNT_WIDTH         = 64,
    parameter logic [31:0] LFSR_SEED         = 32'hACE1_1234
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
    input  logic                         s_axis_pkt_tvalid,
    input  logic                         s_axis_pkt_tlast,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
    output logic                         s_axis_pkt_tready,
    input  logic                         enable,
    input  logic [7:0]                   ready_throttle,
    input  logic                         seq_check_en,
    input  logic                         clear,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic [CNT_WIDTH-1:0]         beat_count,
    output logic [QUEUE_INDEX_WIDTH-1:0] last_queue_id,
    output logic                         err_framing,
    output logic                         err_seq,
    output logic [31:0]                  err_count
);

    localparam int                        BEATS       = beats(PKT_LEN_BYTES, DATA_WIDTH);
    localparam logic [WORD_CNT_WIDTH-1:0] LAST_IDX    = WORD_CNT_WIDTH'(BEATS - 1);
    localparam logic                      SINGLE_BEAT = (BEATS == 1);

    sink_state_t                  state;
    logic [WORD_CNT_WIDTH-1:0]    beat_idx;
    logic [QUEUE_INDEX_WIDTH-1:0] hdr_q;
    logic                         have_prev;

    logic                         accept;
    logic [WORD_CNT_WIDTH-1:0]    word_cnt;
    logic [QUEUE_INDEX_WIDTH-1:0] cur_qid;
    logic [QUEUE_INDEX_WIDTH-1:0] pkt_qid;
    logic [QUEUE_INDEX_WIDTH-1:0] next_qid;
    logic                         keep_ok;
    logic                         frame_err;
    logic                         pkt_done;
    logic                         seq_err;
    logic                         unused_tdata;

    lfsr_backpressure_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_bp_gen (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ready_throttle (ready_throttle),
        .tready         (s_axis_pkt_tready)
    );

    assign accept       = s_axis_pkt_tvalid && s_axis_pkt_tready;
    assign word_cnt     = s_axis_pkt_tdata[WORD_CNT_LSB +: WORD_CNT_WIDTH];
    assign cur_qid      = s_axis_pkt_tdata[QUEUE_ID_LSB +: QUEUE_INDEX_WIDTH];
    assign keep_ok      = &s_axis_pkt_tkeep;
    assign unused_tdata = ^s_axis_pkt_tdata[DATA_WIDTH-1:QUEUE_ID_LSB+QUEUE_INDEX_WIDTH];

    // Single-beat packets complete in HEAD, so the ID comes straight off the bus.
    assign pkt_qid  = (state == HEAD) ? cur_qid : hdr_q;
    assign next_qid = last_queue_id + QUEUE_INDEX_WIDTH'(1);
    assign pkt_done = accept && s_axis_pkt_tlast && !frame_err && (state != DROP);
    assign seq_err  = pkt_done && seq_check_en && have_prev && (pkt_qid != next_qid);

    // Framing check of the accepted beat against its expected position.
    // NOTE: assigning a default first keeps this block free of inferred latches.
    always_comb begin
        frame_err = 1'b0;
        if (accept) begin
            unique case (state)
                HEAD:    frame_err = (word_cnt != '0) || !keep_ok ||
                                     (s_axis_pkt_tlast != SINGLE_BEAT);
                BODY:    frame_err = (word_cnt != beat_idx) || (cur_qid != hdr_q) || !keep_ok ||
                                     (s_axis_pkt_tlast != (beat_idx == LAST_IDX));
                default: frame_err = 1'b0;
            endcase
        end
    end

    // Packet FSM plus counters and sticky flags; clear overrides any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HEAD;
            beat_idx      <= '0;
            hdr_q         <= '0;
            have_prev     <= 1'b0;
            pkt_count     <= '0;
            beat_count    <= '0;
            last_queue_id <= '0;
            err_framing   <= 1'b0;
            err_seq       <= 1'b0;
            err_count     <= '0;
        end else begin
            if (accept) begin
                beat_count <= beat_count + CNT_WIDTH'(1);
                unique case (state)
                    HEAD: begin
                        hdr_q    <= cur_qid;
                        beat_idx <= WORD_CNT_WIDTH'(1);
                        if (frame_err) begin
                            state <= s_axis_pkt_tlast ? HEAD : DROP;
                        end else if (!s_axis_pkt_tlast) begin
                            state <= BODY;
                        end
                    end
                    BODY: begin
                        beat_idx <= beat_idx + WORD_CNT_WIDTH'(1);
                        if (s_axis_pkt_tlast) begin
                            state <= HEAD;
                        end else if (frame_err) begin
                            state <= DROP;
                        end
                    end
                    DROP: begin
                        if (s_axis_pkt_tlast) begin
                            state <= HEAD;
                        end
                    end
                    default: state <= HEAD;
                endcase
            end

            if (pkt_done) begin
                pkt_count     <= pkt_count + CNT_WIDTH'(1);
                last_queue_id <= pkt_qid;
                have_prev     <= 1'b1;
            end
            if (frame_err) begin
                err_framing <= 1'b1;
            end
            if (seq_err) begin
                err_seq <= 1'b1;
            end
            if ((frame_err || seq_err) && (err_count != '1)) begin
                err_count <= err_count + 32'd1;
            end

            if (clear) begin
                pkt_count   <= '0;
                beat_count  <= '0;
                have_prev   <= 1'b0;
                err_framing <= 1'b0;
                err_seq     <= 1'b0;
                err_count   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_sink_checker.sv
// Directed bench for traffic_sink_checker at default parameters (24 beats/packet).
module tb_traffic_sink_checker;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int NB = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tlast;
    logic [KW-1:0]   tkeep;
    logic            tready;
    logic            enable;
    logic [7:0]      ready_throttle;
    logic            seq_check_en;
    logic            clear;
    logic [63:0]     pkt_count;
    logic [63:0]     beat_count;
    logic [15:0]     last_queue_id;
    logic            err_framing;
    logic            err_seq;
    logic [31:0]     err_count;

    int tests = 0;
    int fails = 0;
    int meas_cycles = 0;
    int meas_ready = 0;
    logic meas_on = 1'b0;

    traffic_sink_checker dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_pkt_tdata  (tdata),
        .s_axis_pkt_tvalid (tvalid),
        .s_axis_pkt_tlast  (tlast),
        .s_axis_pkt_tkeep  (tkeep),
        .s_axis_pkt_tready (tready),
        .enable            (enable),
        .ready_throttle    (ready_throttle),
        .seq_check_en      (seq_check_en),
        .clear             (clear),
        .pkt_count         (pkt_count),
        .beat_count        (beat_count),
        .last_queue_id     (last_queue_id),
        .err_framing       (err_framing),
        .err_seq           (err_seq),
        .err_count         (err_count)
    );

    always #5 clk = ~clk;

    // Ready duty measurement, sampled away from the active edge.
    always @(negedge clk) begin
        if (meas_on) begin
            meas_cycles++;
            if (tready) meas_ready++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted, bounded by a cycle budget.
    task automatic send_beat(input logic [15:0] wc, input logic [15:0] qid,
                             input logic last, input logic keep_good);
        int waited;
        waited = 0;
        tdata = '0;
        tdata[100 +: 32] = 32'hDEAD_BEEF;
        tdata[15:0]  = wc;
        tdata[31:16] = qid;
        tkeep  = keep_good ? {KW{1'b1}} : {{(KW-1){1'b1}}, 1'b0};
        tlast  = last;
        tvalid = 1'b1;
        @(negedge clk);
        while (!tready && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (!tready) begin
            check("tready_timeout", 64'(waited), 64'd0);
        end else begin
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Beats first..lst of a packet whose tlast sits at last_idx; optional bad counter / keep beat.
    task automatic send_beats(input logic [15:0] qid, input int first, input int lst,
                              input int last_idx, input int bad_idx, input logic [15:0] bad_wc,
                              input int keep_bad_idx);
        for (int b = first; b <= lst; b++) begin
            send_beat((b == bad_idx) ? bad_wc : 16'(b), qid, b == last_idx, b != keep_bad_idx);
        end
    endtask

    task automatic clean(input logic [15:0] qid);
        send_beats(qid, 0, NB - 1, NB - 1, -1, 16'd0, -1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic expect_all(input string p, input logic [63:0] pc, input logic [63:0] bc,
                              input logic [15:0] lq, input logic ef, input logic es,
                              input logic [31:0] ec);
        check({p, ".pkt_count"},     pkt_count,     pc);
        check({p, ".beat_count"},    beat_count,    bc);
        check({p, ".last_queue_id"}, 64'(last_queue_id), 64'(lq));
        check({p, ".err_framing"},   64'(err_framing), 64'(ef));
        check({p, ".err_seq"},       64'(err_seq),  64'(es));
        check({p, ".err_count"},     64'(err_count), 64'(ec));
    endtask

    task automatic expect_cleared(input string p);
        check({p, ".pkt_count"},   pkt_count,  64'd0);
        check({p, ".beat_count"},  beat_count, 64'd0);
        check({p, ".err_framing"}, 64'(err_framing), 64'd0);
        check({p, ".err_seq"},     64'(err_seq), 64'd0);
        check({p, ".err_count"},   64'(err_count), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pct;
        rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = '1;
        enable = 1'b1; ready_throttle = 8'd0; seq_check_en = 1'b1; clear = 1'b0;
        cycles(3);
        check("reset.tready", 64'(tready), 64'd0);
        expect_all("reset", 0, 0, 16'd0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        cycles(2);
        check("thr0.tready", 64'(tready), 64'd1);

        // Three clean round-robin packets.
        clean(16'd5); clean(16'd6); clean(16'd7);
        expect_all("rr", 3, 72, 16'd7, 1'b0, 1'b0, 0);

        // Clear, then queue ID wrap 65535 -> 0.
        pulse_clear();
        expect_cleared("clear1");
        clean(16'd65535); clean(16'd0);
        expect_all("wrap", 2, 48, 16'd0, 1'b0, 1'b0, 0);

        // Sequence gap 10 -> 12 with and without the check.
        pulse_clear();
        clean(16'd10); clean(16'd12);
        expect_all("seq_on", 2, 48, 16'd12, 1'b0, 1'b1, 1);
        pulse_clear();
        seq_check_en = 1'b0;
        clean(16'd10); clean(16'd12);
        expect_all("seq_off", 2, 48, 16'd12, 1'b0, 1'b0, 0);
        seq_check_en = 1'b1;

        // Early tlast on beat 10, then a clean packet.
        pulse_clear();
        send_beats(16'd20, 0, 10, 10, -1, 16'd0, -1);
        expect_all("early_last", 0, 11, 16'd12, 1'b1, 1'b0, 1);
        clean(16'd21);
        expect_all("after_early", 1, 35, 16'd21, 1'b1, 1'b0, 1);

        // Wrong word counter on beat 2, remainder dropped to tlast.
        pulse_clear();
        send_beats(16'd30, 0, NB - 1, NB - 1, 2, 16'd3, -1);
        expect_all("bad_wc", 0, 24, 16'd21, 1'b1, 1'b0, 1);
        clean(16'd31);
        expect_all("after_bad_wc", 1, 48, 16'd31, 1'b1, 1'b0, 1);

        // Partial tkeep on beat 5.
        pulse_clear();
        send_beats(16'd40, 0, NB - 1, NB - 1, -1, 16'd0, 5);
        expect_all("bad_keep", 0, 24, 16'd31, 1'b1, 1'b0, 1);
        clean(16'd41);
        expect_all("after_keep", 1, 48, 16'd41, 1'b1, 1'b0, 1);

        // Enable dropped mid-packet: stall, then resume in place.
        pulse_clear();
        send_beats(16'd50, 0, 11, NB - 1, -1, 16'd0, -1);
        enable = 1'b0;
        cycles(3);
        check("stall.tready", 64'(tready), 64'd0);
        check("stall.beat_count", beat_count, 64'd12);
        enable = 1'b1;
        send_beats(16'd50, 12, NB - 1, NB - 1, -1, 16'd0, -1);
        expect_all("stall", 1, 24, 16'd50, 1'b0, 1'b0, 0);

        // Clear in the same cycle as an accepted head beat; FSM keeps going.
        clear = 1'b1;
        send_beat(16'd0, 16'd70, 1'b0, 1'b1);
        clear = 1'b0;
        check("clear_wins.beat_count", beat_count, 64'd0);
        send_beats(16'd70, 1, NB - 1, NB - 1, -1, 16'd0, -1);
        expect_all("clear_wins", 1, 23, 16'd70, 1'b0, 1'b0, 0);

        // Reset mid-packet: upstream remainder is one framing error, then recovery.
        send_beats(16'd60, 0, 4, NB - 1, -1, 16'd0, -1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        send_beats(16'd60, 5, NB - 1, NB - 1, -1, 16'd0, -1);
        expect_all("rst_mid", 0, 19, 16'd0, 1'b1, 1'b0, 1);
        clean(16'd61);
        expect_all("after_rst", 1, 43, 16'd61, 1'b1, 1'b0, 1);

        // Heavy throttle over 10 packets with a clear between halves.
        pulse_clear();
        ready_throttle = 8'd200;
        meas_on = 1'b1;
        for (int q = 100; q < 105; q++) clean(16'(q));
        expect_all("thr_a", 5, 120, 16'd104, 1'b0, 1'b0, 0);
        pulse_clear();
        expect_cleared("thr_clear");
        for (int q = 105; q < 110; q++) clean(16'(q));
        meas_on = 1'b0;
        expect_all("thr_b", 5, 120, 16'd109, 1'b0, 1'b0, 0);
        pct = (meas_cycles > 0) ? (meas_ready * 100) / meas_cycles : 0;
        check("thr.duty_15_to_30_pct", 64'(pct >= 15 && pct <= 30), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
